fifo_rd_stream: RTL



---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_rd_stream_if.sv | 13 +
 rtl/fifo_rd_buf.sv | 60 ++++++
 rtl/fifo_rd_stream.sv | 60 ++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types, default sizes and index helper for the FIFO read-side stream stage.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned BUF_DEPTH  = 3;

  typedef logic [DATA_WIDTH-1:0] data_t;

  // Wraps at depth-1, so non-power-of-two depths index correctly.
  function automatic int unsigned idx_inc(int unsigned idx, int unsigned depth);
    return (idx + 32'd1 >= depth) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready output stream of the FIFO read stage.
interface fifo_rd_stream_if #(
  parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/fifo_rd_buf.sv
// Prefetch storage: BUF_DEPTH-entry circular buffer with push/pop indices and fill level.
module fifo_rd_buf #(
  parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int unsigned BUF_DEPTH  = fifo_pkg::BUF_DEPTH,
  localparam int unsigned IdxW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
  localparam int unsigned LvlW = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [LvlW-1:0]       level_o
);

  import fifo_pkg::*;

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [IdxW-1:0]       rd_idx_q, rd_idx_d;
  logic [IdxW-1:0]       wr_idx_q, wr_idx_d;
  logic [LvlW-1:0]       level_q, level_d;

  always_comb begin
    rd_idx_d = rd_idx_q;
    wr_idx_d = wr_idx_q;
    level_d  = level_q;
    if (push_i) wr_idx_d = IdxW'(idx_inc(32'(wr_idx_q), BUF_DEPTH));
    if (pop_i)  rd_idx_d = IdxW'(idx_inc(32'(rd_idx_q), BUF_DEPTH));
    if (push_i && !pop_i) begin
      level_d = level_q + LvlW'(1);
    end else if (!push_i && pop_i) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      level_q  <= '0;
    end else begin
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately not reset; level gates everything that reads it.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_idx_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_idx_q];
  assign level_o = level_q;

  push_never_at_full: assert property (@(posedge clk_i) disable iff (rst_i)
    push_i |-> (level_q != LvlW'(BUF_DEPTH)));

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side output stage: credit-gated prefetch of FIFO words into a valid/ready stream.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int unsigned BUF_DEPTH  = fifo_pkg::BUF_DEPTH,
  localparam int unsigned LvlW = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  fifo_empty,
  output logic                  fifo_ren,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  fifo_rd_stream_if.master      m,
  output logic [LvlW-1:0]       level,
  output logic [15:0]           words_out
);

  import fifo_pkg::*;

  logic        inflight_q, inflight_d;
  logic [15:0] words_out_q, words_out_d;
  logic        credit_ok;
  logic        pop;

  // Counts the word still on its way from the FIFO, so a read never outruns buffer space.
  assign credit_ok = (32'(level) + 32'(inflight_q)) < BUF_DEPTH;

  always_comb begin
    fifo_ren    = !rrst && !fifo_empty && credit_ok;
    inflight_d  = fifo_ren && !fifo_empty;
    m.valid     = !rrst && (level != '0);
    pop         = m.valid && m.ready;
    words_out_d = words_out_q + (pop ? 16'd1 : 16'd0);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      inflight_q  <= 1'b0;
      words_out_q <= '0;
    end else begin
      inflight_q  <= inflight_d;
      words_out_q <= words_out_d;
    end
  end

  assign words_out = words_out_q;

  fifo_rd_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk_i   (rclk),
    .rst_i   (rrst),
    .push_i  (inflight_q),
    .wdata_i (fifo_rdata),
    .pop_i   (pop),
    .rdata_o (m.data),
    .level_o (level)
  );

endmodule
